// File: rtl/uart_mmio_pkg.sv
// Shared register-map constants and types for the UART memory-mapped bridge.
// Offsets index the 8-byte window; bit indices locate fields inside STATUS, CTRL and CLR.
package uart_mmio_pkg;

    localparam logic [2:0] OFF_TX_DATA  = 3'd0;
    localparam logic [2:0] OFF_RX_DATA  = 3'd1;
    localparam logic [2:0] OFF_STATUS   = 3'd2;
    localparam logic [2:0] OFF_CTRL     = 3'd3;
    localparam logic [2:0] OFF_CLR      = 3'd4;
    localparam logic [2:0] OFF_RX_COUNT = 3'd5;
    localparam logic [2:0] OFF_TX_COUNT = 3'd6;
    localparam logic [2:0] OFF_RSVD     = 3'd7;

    localparam int ST_RX_AVAIL   = 0;
    localparam int ST_TX_SPACE   = 1;
    localparam int ST_RX_DROP    = 2;
    localparam int ST_TX_OVF     = 3;
    localparam int ST_RX_UNF     = 4;

    localparam int CTRL_LOOPBACK_EN = 0;
    localparam int CTRL_RX_IRQ_EN   = 1;
    localparam int CTRL_ERR_IRQ_EN  = 2;

    localparam int CLR_RX_DROP   = 2;
    localparam int CLR_TX_OVF    = 3;
    localparam int CLR_RX_UNF    = 4;
    localparam int CLR_COUNTERS  = 7;

    // Field order puts loopback_en at bit 0 so a CTRL write maps straight onto the struct.
    typedef struct packed {
        logic err_irq_en;
        logic rx_irq_en;
        logic loopback_en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{err_irq_en: 1'b0, rx_irq_en: 1'b0, loopback_en: 1'b1};

endpackage

// File: rtl/uart_mmio_arbiter.sv
// Decides which agent owns the TX push and RX pop strobes in a given cycle.
// CPU accesses win; loopback only moves a byte when the CPU leaves both FIFOs alone.
module uart_mmio_arbiter (
    input  logic i_reset_n,
    input  logic i_cpuPush,
    input  logic i_cpuRxAccess,
    input  logic i_cpuPop,
    input  logic i_loopbackEn,
    input  logic i_rxEmpty,
    input  logic i_txFull,
    output logic o_txWriteEn,
    output logic o_txSelCpu,
    output logic o_rxReadEn
);

    logic w_loopbackMove;

    assign w_loopbackMove = i_loopbackEn & !i_rxEmpty & !i_txFull & !i_cpuPush & !i_cpuRxAccess;

    // Reset gating keeps the FIFOs untouched while the bridge registers are being initialised.
    assign o_txWriteEn = i_reset_n & (i_cpuPush | w_loopbackMove);
    assign o_rxReadEn  = i_reset_n & (i_cpuPop  | w_loopbackMove);
    assign o_txSelCpu  = i_cpuPush;

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped front end between the core data port and the UART RX/TX FIFOs,
// with status/control/counter registers, sticky error flags and software-controlled loopback.
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter int                  DATA_W    = 8,
    parameter int                  D_ADDR_W  = 12,
    parameter logic [D_ADDR_W-1:0] BASE_ADDR = 12'hFF8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [D_ADDR_W-1:0] data_addr,
    input  logic                write_enable,
    input  logic                read_enable,
    input  logic [DATA_W-1:0]   write_data,
    output logic [DATA_W-1:0]   read_data,
    output logic                int_mem_select,
    output logic                tx_fifo_write_en,
    output logic [DATA_W-1:0]   tx_fifo_write_data,
    input  logic                tx_fifo_full,
    output logic                rx_fifo_read_en,
    input  logic [DATA_W-1:0]   rx_fifo_read_data,
    input  logic                rx_fifo_empty,
    input  logic                rx_drop,
    output logic                irq
);

    if (BASE_ADDR[2:0] != 3'b000) begin : g_baseAlignCheck
        $error("uart_mmio_bridge: BASE_ADDR must be 8-byte aligned");
    end
    if (DATA_W < 8) begin : g_dataWidthCheck
        $error("uart_mmio_bridge: DATA_W must be at least 8");
    end

    logic              w_hit;
    logic [2:0]        w_off;
    logic              w_cpuPush;
    logic              w_cpuRxAccess;
    logic              w_cpuPop;
    logic              w_txOverflow;
    logic              w_rxUnderflow;
    logic              w_ctrlWr;
    logic              w_clrWr;
    logic              w_clrCounters;
    logic              w_txSelCpu;
    logic [DATA_W-1:0] w_readData;

    ctrl_t             r_ctrl;
    logic              r_rxDropSticky;
    logic              r_txOvfSticky;
    logic              r_rxUnfSticky;
    logic [DATA_W-1:0] r_rxCount;
    logic [DATA_W-1:0] r_txCount;
    logic              r_irq;

    assign w_hit = (data_addr[D_ADDR_W-1:3] == BASE_ADDR[D_ADDR_W-1:3]);
    assign w_off = data_addr[2:0];
    assign int_mem_select = !w_hit;

    assign w_cpuRxAccess = read_enable  & w_hit & (w_off == OFF_RX_DATA);
    assign w_cpuPop      = w_cpuRxAccess & !rx_fifo_empty;
    assign w_rxUnderflow = w_cpuRxAccess &  rx_fifo_empty;
    assign w_cpuPush     = write_enable & w_hit & (w_off == OFF_TX_DATA) & !tx_fifo_full;
    assign w_txOverflow  = write_enable & w_hit & (w_off == OFF_TX_DATA) &  tx_fifo_full;
    assign w_ctrlWr      = write_enable & w_hit & (w_off == OFF_CTRL);
    assign w_clrWr       = write_enable & w_hit & (w_off == OFF_CLR);
    assign w_clrCounters = w_clrWr & write_data[CLR_COUNTERS];

    uart_mmio_arbiter u_arbiter (
        .i_reset_n     (reset_n),
        .i_cpuPush     (w_cpuPush),
        .i_cpuRxAccess (w_cpuRxAccess),
        .i_cpuPop      (w_cpuPop),
        .i_loopbackEn  (r_ctrl.loopback_en),
        .i_rxEmpty     (rx_fifo_empty),
        .i_txFull      (tx_fifo_full),
        .o_txWriteEn   (tx_fifo_write_en),
        .o_txSelCpu    (w_txSelCpu),
        .o_rxReadEn    (rx_fifo_read_en)
    );

    assign tx_fifo_write_data = w_txSelCpu ? write_data : rx_fifo_read_data;

    always_comb begin
        w_readData = '0;
        unique case (w_off)
            OFF_RX_DATA:  w_readData = rx_fifo_empty ? '0 : rx_fifo_read_data;
            OFF_STATUS: begin
                w_readData[ST_RX_AVAIL] = !rx_fifo_empty;
                w_readData[ST_TX_SPACE] = !tx_fifo_full;
                w_readData[ST_RX_DROP]  = r_rxDropSticky;
                w_readData[ST_TX_OVF]   = r_txOvfSticky;
                w_readData[ST_RX_UNF]   = r_rxUnfSticky;
            end
            OFF_CTRL: begin
                w_readData[CTRL_LOOPBACK_EN] = r_ctrl.loopback_en;
                w_readData[CTRL_RX_IRQ_EN]   = r_ctrl.rx_irq_en;
                w_readData[CTRL_ERR_IRQ_EN]  = r_ctrl.err_irq_en;
            end
            OFF_RX_COUNT: w_readData = r_rxCount;
            OFF_TX_COUNT: w_readData = r_txCount;
            OFF_TX_DATA, OFF_CLR, OFF_RSVD: w_readData = '0;
            default:      w_readData = '0;
        endcase
    end

    assign read_data = w_hit ? w_readData : '0;

    // Sticky flags give set priority over a same-cycle CLR so no event is ever lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl         <= CTRL_RESET;
            r_rxDropSticky <= 1'b0;
            r_txOvfSticky  <= 1'b0;
            r_rxUnfSticky  <= 1'b0;
            r_rxCount      <= '0;
            r_txCount      <= '0;
            r_irq          <= 1'b0;
        end else begin
            if (w_ctrlWr) begin
                r_ctrl <= ctrl_t'(write_data[2:0]);
            end

            if (rx_drop) begin
                r_rxDropSticky <= 1'b1;
            end else if (w_clrWr && write_data[CLR_RX_DROP]) begin
                r_rxDropSticky <= 1'b0;
            end

            if (w_txOverflow) begin
                r_txOvfSticky <= 1'b1;
            end else if (w_clrWr && write_data[CLR_TX_OVF]) begin
                r_txOvfSticky <= 1'b0;
            end

            if (w_rxUnderflow) begin
                r_rxUnfSticky <= 1'b1;
            end else if (w_clrWr && write_data[CLR_RX_UNF]) begin
                r_rxUnfSticky <= 1'b0;
            end

            if (w_clrCounters) begin
                r_rxCount <= '0;
            end else if (rx_fifo_read_en) begin
                r_rxCount <= r_rxCount + DATA_W'(1);
            end

            if (w_clrCounters) begin
                r_txCount <= '0;
            end else if (tx_fifo_write_en) begin
                r_txCount <= r_txCount + DATA_W'(1);
            end

            r_irq <= (r_ctrl.rx_irq_en & !rx_fifo_empty) |
                     (r_ctrl.err_irq_en & (r_rxDropSticky | r_txOvfSticky | r_rxUnfSticky));
        end
    end

    assign irq = r_irq;

endmodule
